lsu_wb_unit: RTL and testbench
==============================

Name: lsu_wb_unit

Overview:
- Load/store unit plus writeback stage, directly upstream of the integer register file and CSR block.
- Accepts one memory op from execute, issues it on a valid/ready data bus, and formats load data (byte/half, sign/zero extension).
- Drives the register-file write port (wen/waddr/wdata) and reports misaligned or access faults as mcause/mepc values for the CSR trap logic.

Parameters:
- ADDR_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT, 255, maximum cycles to wait for a bus response before raising an access fault.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  op from execute is valid.
- in_ready  out  1  unit can accept an op; high only in IDLE.
- in_load  in  1  op is a load.
- in_store  in  1  op is a store; in_load and in_store are never both 1.
- in_funct3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- in_addr  in  32  effective address.
- in_wdata  in  32  store data, low-aligned.
- in_rd  in  ADDR_WIDTH  load destination register.
- in_pc  in  32  pc of the op, used for fault reporting.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_addr  out  32  word-aligned address.
- mem_req_wen  out  1  1 = write.
- mem_req_wdata  out  32  store data shifted into byte lanes.
- mem_req_wmask  out  4  byte strobes.
- mem_resp_valid  in  1  response valid; the unit is always ready for it.
- mem_resp_rdata  in  32  read word.
- mem_resp_err  in  1  bus error.
- rf_wen  out  1  register write enable, 1-cycle pulse.
- rf_waddr  out  ADDR_WIDTH  register write address.
- rf_wdata  out  DATA_WIDTH  register write data.
- done  out  1  op retired, 1-cycle pulse; also pulses on fault.
- fault_valid  out  1  trap request, 1-cycle pulse, coincident with done.
- fault_cause  out  32  4 load-misaligned, 5 load-access, 6 store-misaligned, 7 store-access.
- fault_epc  out  32  pc of the faulting op.

Behaviour:
- States: IDLE, REQ, WAIT, WB.
- Reset: state IDLE, timeout counter 0. All outputs 0 except in_ready = 1.
- IDLE:
  - Accept the op on in_valid & in_ready and latch all in_* fields.
  - Misaligned check: h with addr[0] = 1, or w with addr[1:0] != 0.
  - Misaligned -> WB with fault (cause 4 or 6); no bus request is issued.
  - Otherwise -> REQ.
  - in_valid with neither in_load nor in_store -> ignored; stays IDLE.
- REQ:
  - mem_req_valid = 1, held until mem_req_ready; request fields are stable while valid.
  - mem_req_addr = {addr[31:2], 2'b00}.
  - wmask: b 0001 << addr[1:0]; h 0011 << addr[1:0]; w 1111; loads 0000.
  - wdata: store data << 8*addr[1:0].
  - Handshake -> WAIT, counter cleared.
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid & !mem_resp_err -> WB; load data is captured.
  - mem_resp_err, or counter reaching TIMEOUT with no response -> WB with access fault (5 or 7).
  - A response arriving in the same cycle the counter reaches TIMEOUT is accepted as a normal response.
- WB (exactly 1 cycle, then -> IDLE):
  - done = 1.
  - Load without fault and rd != 0: rf_wen = 1, rf_waddr = rd, rf_wdata = formatted data.
  - Formatting: select the byte/half lane by addr[1:0]; b/h sign-extend, bu/hu zero-extend, w passes through.
  - Store, or rd == 0: rf_wen = 0.
  - Fault: fault_valid = 1, fault_cause and fault_epc driven, rf_wen = 0.
- Latency (zero-wait bus): accept T, request T+1, response T+2, WB T+3. Throughput is 1 op per 4 cycles minimum.
- Reset asserted mid-op: return to IDLE immediately. An outstanding bus response after reset is ignored, because it is only sampled in WAIT.
- Outputs outside WB are 0. rf_waddr and rf_wdata may hold stale values while rf_wen = 0.

Decomposition:
- Shared package:
  - funct3 encodings (LB, LH, LW, LBU, LHU; SB, SH, SW).
  - mcause constants 4–7.
  - State enum.
- One sub-module: lsu_load_align. Purely combinational: (rdata, addr[1:0], funct3) -> formatted 32-bit value. Store lane shifting stays inline.

Test Plan:
- lw from 0x80000004, rd = 5, bus returns 0xDEADBEEF with zero wait -> rf_wen at T+3, waddr 5, wdata 0xDEADBEEF, done = 1.
- lb from 0x80000003, rdata 0x80FF1234 -> wdata 0xFFFFFF80. lbu from the same address -> 0x00000080. lhu from 0x80000002 -> 0x000080FF.
- sh of 0x0000ABCD to 0x80000002 -> mem_req_wmask 1100, wdata 0xABCD0000, wen = 1; rf_wen stays 0; done pulses.
- lw from 0x80000001, pc 0x80000010 -> no mem_req_valid; fault_valid with cause 4, epc 0x80000010, rf_wen = 0.
- mem_req_ready held low for 3 cycles -> request fields stable throughout. Then mem_resp_err = 1 on a store -> fault cause 7.
- No response for TIMEOUT cycles -> cause 5 (load). Separately, rst driven low while in WAIT -> state IDLE, in_ready = 1, and a late response produces no rf_wen.

Source files
------------

// File: rtl/lsu_wb_unit_pkg.sv
// Shared encodings for the load/store + writeback unit: funct3 codes, mcause values,
// FSM state codes and the latched-op record.
package lsu_wb_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] MCAUSE_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] MCAUSE_LOAD_ACCESS    = 32'd5;
  localparam logic [31:0] MCAUSE_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] MCAUSE_STORE_ACCESS   = 32'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } lsu_op_t;

  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (size_of(funct3))
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_wb_unit_if.sv
// Bundle of execute-side, data-bus, register-file and trap signals of the LSU.
// The unit sits on the slave modport; its environment drives the master side.
interface lsu_wb_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_load;
  logic                  in_store;
  logic [2:0]            in_funct3;
  logic [31:0]           in_addr;
  logic [31:0]           in_wdata;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic [31:0]           in_pc;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [31:0]           mem_req_addr;
  logic                  mem_req_wen;
  logic [31:0]           mem_req_wdata;
  logic [3:0]            mem_req_wmask;
  logic                  mem_resp_valid;
  logic [31:0]           mem_resp_rdata;
  logic                  mem_resp_err;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  done;
  logic                  fault_valid;
  logic [31:0]           fault_cause;
  logic [31:0]           fault_epc;

  modport master (
    output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd, in_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  rf_wen, rf_waddr, rf_wdata, done, fault_valid, fault_cause, fault_epc
  );

  modport slave (
    input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd, in_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output rf_wen, rf_waddr, rf_wdata, done, fault_valid, fault_cause, fault_epc
  );

endinterface

// File: rtl/lsu_load_align.sv
// Load data formatter: picks the byte/half lane out of the bus word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_wb_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb_unit.sv
// Load/store unit and writeback stage: one op at a time, issued on a valid/ready bus,
// retired through the register-file write port or reported as a trap.
module lsu_wb_unit
  import lsu_wb_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  lsu_wb_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  lsu_op_t               r_op;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [31:0]           r_rdata;
  logic                  r_fault;
  logic [31:0]           r_cause;

  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_timeout;
  logic                  w_in_req;
  logic                  w_in_wb;
  logic [3:0]            w_mask;
  logic [31:0]           w_wdata_sh;
  logic [31:0]           w_ld_data;
  logic [DATA_WIDTH-1:0] w_rf_data;

  // Ops that are neither load nor store are dropped without leaving IDLE.
  assign w_accept   = bus.in_valid & (bus.in_load | bus.in_store) & (r_state == ST_IDLE);
  assign w_misalign = is_misaligned(bus.in_funct3, bus.in_addr[1:0]);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
      r_cause <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op.is_load <= bus.in_load;
            r_op.funct3  <= bus.in_funct3;
            r_op.addr    <= bus.in_addr;
            r_op.wdata   <= bus.in_wdata;
            r_op.pc      <= bus.in_pc;
            r_rd         <= bus.in_rd;
            r_fault      <= w_misalign;
            r_cause      <= bus.in_load ? MCAUSE_LOAD_MISALIGN : MCAUSE_STORE_MISALIGN;
            r_state      <= w_misalign ? ST_WB : ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A response wins over a timeout landing in the same cycle.
          if (bus.mem_resp_valid) begin
            r_state <= ST_WB;
            if (bus.mem_resp_err) begin
              r_fault <= 1'b1;
              r_cause <= r_op.is_load ? MCAUSE_LOAD_ACCESS : MCAUSE_STORE_ACCESS;
            end else begin
              r_rdata <= bus.mem_resp_rdata;
            end
          end else if (w_timeout) begin
            r_state <= ST_WB;
            r_fault <= 1'b1;
            r_cause <= r_op.is_load ? MCAUSE_LOAD_ACCESS : MCAUSE_STORE_ACCESS;
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_in_req = (r_state == ST_REQ);
  assign w_in_wb  = (r_state == ST_WB);

  always_comb begin
    w_mask = 4'b0000;
    if (!r_op.is_load) begin
      case (r_op.funct3)
        F3_SB:   w_mask = 4'b0001 << r_op.addr[1:0];
        F3_SH:   w_mask = 4'b0011 << r_op.addr[1:0];
        F3_SW:   w_mask = 4'b1111;
        default: w_mask = 4'b1111;
      endcase
    end
  end

  assign w_wdata_sh = r_op.wdata << {r_op.addr[1:0], 3'b000};

  assign bus.in_ready      = (r_state == ST_IDLE);
  assign bus.mem_req_valid = w_in_req;
  assign bus.mem_req_addr  = w_in_req ? {r_op.addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_req_wen   = w_in_req & ~r_op.is_load;
  assign bus.mem_req_wdata = (w_in_req & ~r_op.is_load) ? w_wdata_sh : 32'd0;
  assign bus.mem_req_wmask = w_in_req ? w_mask : 4'b0000;

  lsu_load_align u_load_align (
    .i_rdata   (r_rdata),
    .i_addr_lo (r_op.addr[1:0]),
    .i_funct3  (r_op.funct3),
    .o_data    (w_ld_data)
  );

  assign w_rf_data = w_ld_data;

  // Writes to x0 are suppressed here so the register file never sees them.
  assign bus.rf_wen      = w_in_wb & r_op.is_load & ~r_fault & (r_rd != '0);
  assign bus.rf_waddr    = r_rd;
  assign bus.rf_wdata    = w_rf_data;
  assign bus.done        = w_in_wb;
  assign bus.fault_valid = w_in_wb & r_fault;
  assign bus.fault_cause = (w_in_wb & r_fault) ? r_cause : 32'd0;
  assign bus.fault_epc   = (w_in_wb & r_fault) ? r_op.pc : 32'd0;

endmodule

// File: tb/tb_lsu_wb_unit.sv
// Directed bench for lsu_wb_unit: hand-computed loads, stores, faults, timeout and reset abort.
module tb_lsu_wb_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_wb_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  lsu_wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic        res_done;
  int          res_done_cyc;
  logic        res_req_seen;
  logic        res_stable;
  logic [31:0] res_req_addr;
  logic        res_req_wen;
  logic [31:0] res_req_wdata;
  logic [3:0]  res_req_mask;
  logic        res_rf_wen;
  logic [4:0]  res_rf_waddr;
  logic [31:0] res_rf_wdata;
  logic        res_fv;
  logic [31:0] res_fc;
  logic [31:0] res_fe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.in_load        = 1'b0;
    bus.in_store       = 1'b0;
    bus.in_funct3      = 3'd0;
    bus.in_addr        = 32'd0;
    bus.in_wdata       = 32'd0;
    bus.in_rd          = 5'd0;
    bus.in_pc          = 32'd0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 32'd0;
    bus.mem_resp_err   = 1'b0;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the WB cycle.
  task automatic run_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] pc, input int rdy_dly, input logic [31:0] rdata,
                        input logic err, input logic noresp);
    int rdy_cnt = 0;
    bit hs = 1'b0;
    bit fin = 1'b0;
    res_done = 1'b0; res_done_cyc = -1; res_req_seen = 1'b0; res_stable = 1'b1;
    res_req_addr = '0; res_req_wen = 1'b0; res_req_wdata = '0; res_req_mask = '0;
    res_rf_wen = 1'b0; res_rf_waddr = '0; res_rf_wdata = '0;
    res_fv = 1'b0; res_fc = '0; res_fe = '0;
    bus.in_valid  = 1'b1;
    bus.in_load   = ld;
    bus.in_store  = ~ld;
    bus.in_funct3 = f3;
    bus.in_addr   = addr;
    bus.in_wdata  = wd;
    bus.in_rd     = rd;
    bus.in_pc     = pc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
      if (bus.done) begin
        fin = 1'b1;
        res_done_cyc = cyc;
        res_rf_wen = bus.rf_wen; res_rf_waddr = bus.rf_waddr; res_rf_wdata = bus.rf_wdata;
        res_fv = bus.fault_valid; res_fc = bus.fault_cause; res_fe = bus.fault_epc;
      end else if (bus.mem_req_valid) begin
        if (!res_req_seen) begin
          res_req_seen = 1'b1;
          res_req_addr = bus.mem_req_addr; res_req_wen = bus.mem_req_wen;
          res_req_wdata = bus.mem_req_wdata; res_req_mask = bus.mem_req_wmask;
        end else if (bus.mem_req_addr !== res_req_addr || bus.mem_req_wen !== res_req_wen ||
                     bus.mem_req_wdata !== res_req_wdata || bus.mem_req_wmask !== res_req_mask) begin
          res_stable = 1'b0;
        end
        if (rdy_cnt == rdy_dly) begin
          bus.mem_req_ready = 1'b1;
          hs = 1'b1;
        end else begin
          rdy_cnt++;
        end
      end else if (hs && !noresp) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = rdata;
        bus.mem_resp_err   = err;
      end
      @(posedge clk); #1;
    end
    res_done = fin;
    idle_inputs();
    chk({tag, "_done"}, {31'd0, res_done}, 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_wmask", {28'd0, bus.mem_req_wmask}, 32'd0);
    chk("rst_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_fault", {31'd0, bus.fault_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("lw", 1'b1, 3'b010, 32'h8000_0004, 32'd0, 5'd5, 32'h8000_0100, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("lw_cyc", res_done_cyc, 32'd3);
    chk("lw_req_addr", res_req_addr, 32'h8000_0004);
    chk("lw_req_wen", {31'd0, res_req_wen}, 32'd0);
    chk("lw_req_mask", {28'd0, res_req_mask}, 32'd0);
    chk("lw_rf_wen", {31'd0, res_rf_wen}, 32'd1);
    chk("lw_waddr", {27'd0, res_rf_waddr}, 32'd5);
    chk("lw_wdata", res_rf_wdata, 32'hDEAD_BEEF);
    chk("lw_fault", {31'd0, res_fv}, 32'd0);

    run_op("lb3", 1'b1, 3'b000, 32'h8000_0003, 32'd0, 5'd6, 32'h8000_0104, 0, 32'h80FF_1234, 1'b0, 1'b0);
    chk("lb3_rf_wen", {31'd0, res_rf_wen}, 32'd1);
    chk("lb3_wdata", res_rf_wdata, 32'hFFFF_FF80);
    run_op("lbu3", 1'b1, 3'b100, 32'h8000_0003, 32'd0, 5'd6, 32'h8000_0108, 0, 32'h80FF_1234, 1'b0, 1'b0);
    chk("lbu3_wdata", res_rf_wdata, 32'h0000_0080);
    run_op("lhu2", 1'b1, 3'b101, 32'h8000_0002, 32'd0, 5'd7, 32'h8000_010C, 0, 32'h80FF_1234, 1'b0, 1'b0);
    chk("lhu2_wdata", res_rf_wdata, 32'h0000_80FF);
    run_op("lh2", 1'b1, 3'b001, 32'h8000_0002, 32'd0, 5'd7, 32'h8000_0110, 0, 32'h80FF_1234, 1'b0, 1'b0);
    chk("lh2_wdata", res_rf_wdata, 32'hFFFF_80FF);
    run_op("lb1", 1'b1, 3'b000, 32'h8000_0001, 32'd0, 5'd8, 32'h8000_0114, 0, 32'h80FF_1234, 1'b0, 1'b0);
    chk("lb1_wdata", res_rf_wdata, 32'h0000_0012);

    run_op("sh", 1'b0, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd9, 32'h8000_0118, 0, 32'd0, 1'b0, 1'b0);
    chk("sh_cyc", res_done_cyc, 32'd3);
    chk("sh_req_addr", res_req_addr, 32'h8000_0000);
    chk("sh_req_wen", {31'd0, res_req_wen}, 32'd1);
    chk("sh_req_mask", {28'd0, res_req_mask}, 32'hC);
    chk("sh_req_wdata", res_req_wdata, 32'hABCD_0000);
    chk("sh_rf_wen", {31'd0, res_rf_wen}, 32'd0);
    chk("sh_fault", {31'd0, res_fv}, 32'd0);

    run_op("sw", 1'b0, 3'b010, 32'h8000_0008, 32'h1234_5678, 5'd0, 32'h8000_011C, 0, 32'd0, 1'b0, 1'b0);
    chk("sw_req_mask", {28'd0, res_req_mask}, 32'hF);
    chk("sw_req_wdata", res_req_wdata, 32'h1234_5678);

    run_op("lw_mis", 1'b1, 3'b010, 32'h8000_0001, 32'd0, 5'd5, 32'h8000_0010, 0, 32'd0, 1'b0, 1'b0);
    chk("lw_mis_req", {31'd0, res_req_seen}, 32'd0);
    chk("lw_mis_cyc", res_done_cyc, 32'd1);
    chk("lw_mis_fv", {31'd0, res_fv}, 32'd1);
    chk("lw_mis_cause", res_fc, 32'd4);
    chk("lw_mis_epc", res_fe, 32'h8000_0010);
    chk("lw_mis_rf_wen", {31'd0, res_rf_wen}, 32'd0);

    run_op("sh_mis", 1'b0, 3'b001, 32'h8000_0003, 32'h0000_1111, 5'd0, 32'h8000_0014, 0, 32'd0, 1'b0, 1'b0);
    chk("sh_mis_req", {31'd0, res_req_seen}, 32'd0);
    chk("sh_mis_cause", res_fc, 32'd6);

    run_op("sb_err", 1'b0, 3'b000, 32'h8000_0001, 32'h0000_00EF, 5'd0, 32'h8000_0020, 3, 32'd0, 1'b1, 1'b0);
    chk("sb_err_stable", {31'd0, res_stable}, 32'd1);
    chk("sb_err_mask", {28'd0, res_req_mask}, 32'h2);
    chk("sb_err_wdata", res_req_wdata, 32'h0000_EF00);
    chk("sb_err_cyc", res_done_cyc, 32'd6);
    chk("sb_err_fv", {31'd0, res_fv}, 32'd1);
    chk("sb_err_cause", res_fc, 32'd7);
    chk("sb_err_epc", res_fe, 32'h8000_0020);

    run_op("lw_rd0", 1'b1, 3'b010, 32'h8000_0040, 32'd0, 5'd0, 32'h8000_0024, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    chk("lw_rd0_rf_wen", {31'd0, res_rf_wen}, 32'd0);

    run_op("lh_to", 1'b1, 3'b001, 32'h8000_0006, 32'd0, 5'd3, 32'h8000_0030, 0, 32'd0, 1'b0, 1'b1);
    chk("lh_to_late", {31'd0, res_done_cyc >= 257}, 32'd1);
    chk("lh_to_fv", {31'd0, res_fv}, 32'd1);
    chk("lh_to_cause", res_fc, 32'd5);
    chk("lh_to_epc", res_fe, 32'h8000_0030);
    chk("lh_to_rf_wen", {31'd0, res_rf_wen}, 32'd0);

    bus.in_valid = 1'b1;
    bus.in_addr  = 32'h8000_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("nop_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("nop_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);

    bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_funct3 = 3'b010;
    bus.in_addr = 32'h8000_0010; bus.in_rd = 5'd7; bus.in_pc = 32'h8000_0040;
    @(posedge clk); #1;
    idle_inputs();
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstw_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rstw_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rstw_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("late_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
      chk("late_done", {31'd0, bus.done}, 32'd0);
    end
    bus.mem_resp_valid = 1'b0;
    chk("late_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
